// File: rtl/collector_pkg.sv
// collector_pkg: shared types and defaults for the byte-to-word collector.
//   state_e           - packing FSM state (IDLE: no bytes held, COLLECT: partial word held)
//   DEF_*             - default parameter values for the collector and its FIFO
//   cnt_w(depth)      - width of an occupancy counter able to hold 0..depth
package collector_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WORD_BEATS  = 2;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TIMEOUT_CYC = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/collector_sync_fifo.sv
// collector_sync_fifo: single-clock FIFO with a combinational head.
//   clk, reset       - clock, synchronous active-high reset
//   wr_en, wr_data   - push (ignored when full)
//   rd_en            - pop (ignored when empty)
//   rd_data          - head entry; when empty, holds the last popped entry (0 after reset)
//   count            - entries stored
//   full, empty      - occupancy flags
module collector_sync_fifo
  import collector_pkg::*;
#(
  parameter int W     = DEF_DATA_W * DEF_WORD_BEATS + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [W-1:0]                    wr_data,
  input  logic                            rd_en,
  output logic [W-1:0]                    rd_data,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            full,
  output logic                            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     hold_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Once drained, the head slot may hold stale data from an earlier lap,
  // so the output falls back to the last word actually handed out.
  assign rd_data = empty ? hold_q : mem[rd_ptr];

endmodule

// File: rtl/byte_word_collector.sv
// byte_word_collector: packs a valid/ready byte stream into little-endian words,
// buffers them in a FIFO and presents them on a valid/ready word port.
//   clk, reset          - clock, synchronous active-high reset
//   data_bus, valid     - input beat and qualifier
//   ready               - a beat can be accepted (FIFO not full)
//   flush               - close the current partial word (zero-padded, word_partial=1)
//   word_out            - FIFO head word
//   word_partial        - head word was closed by flush
//   word_valid          - FIFO non-empty
//   word_ready          - downstream takes the head word
//   fifo_count          - words stored
//   timeout_pulse       - one-cycle pulse when an idle partial word is discarded
// Optional build macro COLLECTOR_TIMEOUT_EN enables the idle-timeout discard;
// without it partial words are held indefinitely and timeout_pulse is 0.
module byte_word_collector
  import collector_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WORD_BEATS  = DEF_WORD_BEATS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_W-1:0]                 data_bus,
  input  logic                              valid,
  output logic                              ready,
  input  logic                              flush,
  output logic [DATA_W*WORD_BEATS-1:0]      word_out,
  output logic                              word_partial,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              timeout_pulse
);

  localparam int WORD_W = DATA_W * WORD_BEATS;
  localparam int BEAT_W = $clog2(WORD_BEATS);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WORD_W-1:0]   asm_q, asm_d, merged;

  logic accept, last_beat, flush_act, push, push_partial, expire;
  logic fifo_full, fifo_empty;

  assign ready     = !fifo_full;
  assign accept    = valid && ready;
  assign last_beat = accept && (beat_q == BEAT_W'(WORD_BEATS - 1));
  // Flush only matters with bytes held and room to store the word.
  assign flush_act = flush && (state_q == COLLECT) && !fifo_full;
  // A flush whose concurrent beat completes the word is just a normal push.
  assign push         = last_beat || flush_act;
  assign push_partial = flush_act && !last_beat;

  // Assembly register with the incoming beat merged in. Unfilled lanes are
  // already zero because the register is cleared whenever a word closes.
  always_comb begin
    merged = asm_q;
    if (accept) merged[beat_q*DATA_W +: DATA_W] = data_bus;
  end

`ifdef COLLECTOR_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q;
  logic              pulse_q;

  // Expires on the TIMEOUT_CYC-th consecutive beat-less cycle in COLLECT;
  // a beat or a flush in that cycle takes priority.
  assign expire = (state_q == COLLECT) && !accept && !flush_act &&
                  (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= expire;
      if (accept || state_d != COLLECT) idle_q <= '0;
      else                               idle_q <= idle_q + IDLE_W'(1);
    end
  end

  assign timeout_pulse = pulse_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign expire         = 1'b0;
  assign timeout_pulse  = 1'b0;
`endif

  // Next-state / assembly update
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    if (push || expire) begin
      state_d = IDLE;
      beat_d  = '0;
      asm_d   = '0;
    end else if (accept) begin
      state_d = COLLECT;
      beat_d  = beat_q + BEAT_W'(1);
      asm_d   = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
    end
  end

  logic [WORD_W:0] fifo_rd;

  collector_sync_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({push_partial, merged}),
    .rd_en   (word_valid && word_ready),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign word_valid   = !fifo_empty;
  assign word_out     = fifo_rd[WORD_W-1:0];
  assign word_partial = fifo_rd[WORD_W];

endmodule

// File: tb/tb_byte_word_collector.sv
module tb_byte_word_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_bus;
  logic        valid;
  logic        ready;
  logic        flush;
  logic [15:0] word_out;
  logic        word_partial;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fifo_count;
  logic        timeout_pulse;

  int n_checks = 0;
  int n_errors = 0;

  byte_word_collector dut (
    .clk           (clk),
    .reset         (reset),
    .data_bus      (data_bus),
    .valid         (valid),
    .ready         (ready),
    .flush         (flush),
    .word_out      (word_out),
    .word_partial  (word_partial),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .fifo_count    (fifo_count),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_heads [4];
  int pulses;

  initial begin
    exp_heads[0] = 16'h0302;
    exp_heads[1] = 16'h0504;
    exp_heads[2] = 16'h0706;
    exp_heads[3] = 16'h0908;

    reset = 1'b1; data_bus = '0; valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_ready",   32'(ready), 1);
    chk("rst_wvalid",  32'(word_valid), 0);
    chk("rst_count",   32'(fifo_count), 0);
    chk("rst_wout",    32'(word_out), 0);
    chk("rst_partial", 32'(word_partial), 0);
    chk("rst_tpulse",  32'(timeout_pulse), 0);

    // Flush in IDLE does nothing
    flush = 1'b1; step(); flush = 1'b0;
    chk("idle_flush_count",  32'(fifo_count), 0);
    chk("idle_flush_wvalid", 32'(word_valid), 0);

    // Packing: 0x34, 0x12 -> 0x1234 visible the cycle after the second beat
    word_ready = 1'b1;
    valid = 1'b1; data_bus = 8'h34; step();
    chk("pack_wvalid_early", 32'(word_valid), 0);
    data_bus = 8'h12; step(); valid = 1'b0;
    chk("pack_wvalid", 32'(word_valid), 1);
    chk("pack_wout",   32'(word_out), 32'h1234);
    chk("pack_partial", 32'(word_partial), 0);
    step();
    chk("pack_popped", 32'(fifo_count), 0);

    // Full: stream 0x00..0x07 with no consumer
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; data_bus = 8'(i); step();
    end
    chk("full_ready", 32'(ready), 0);
    chk("full_count", 32'(fifo_count), 4);
    data_bus = 8'h08; step(); step();
    chk("full_held_count", 32'(fifo_count), 4);
    chk("full_head", 32'(word_out), 32'h0100);
    word_ready = 1'b1; step(); word_ready = 1'b0;
    chk("pop_ready", 32'(ready), 1);
    chk("pop_count", 32'(fifo_count), 3);
    step();
    data_bus = 8'h09; step(); valid = 1'b0;
    chk("refill_count", 32'(fifo_count), 4);
    word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_head%0d", k), 32'(word_out), 32'(exp_heads[k]));
      step();
    end
    word_ready = 1'b0;
    chk("drain_wvalid", 32'(word_valid), 0);
    chk("drain_hold",   32'(word_out), 32'h0908);

    // Flush after one beat -> zero-padded partial word
    valid = 1'b1; data_bus = 8'hAB; step();
    valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    chk("flush_wvalid",  32'(word_valid), 1);
    chk("flush_wout",    32'(word_out), 32'h00AB);
    chk("flush_partial", 32'(word_partial), 1);
    word_ready = 1'b1; step(); word_ready = 1'b0;

    // Flush with a concurrent completing beat -> normal word
    valid = 1'b1; data_bus = 8'hAB; step();
    data_bus = 8'hCD; flush = 1'b1; step();
    valid = 1'b0; flush = 1'b0;
    chk("flushbeat_wout",    32'(word_out), 32'hCDAB);
    chk("flushbeat_partial", 32'(word_partial), 0);
    chk("flushbeat_count",   32'(fifo_count), 1);
    word_ready = 1'b1; step(); word_ready = 1'b0;

    // Reset mid-word discards the partial byte
    valid = 1'b1; data_bus = 8'h55; step();
    valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    valid = 1'b1; data_bus = 8'h01; step();
    data_bus = 8'h02; step(); valid = 1'b0;
    chk("midrst_count", 32'(fifo_count), 1);
    chk("midrst_wout",  32'(word_out), 32'h0201);
    word_ready = 1'b1; step(); word_ready = 1'b0;

    // Idle partial word: discarded only when the timeout is built in
    valid = 1'b1; data_bus = 8'h77; step(); valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (timeout_pulse) pulses++;
      step();
    end
    chk("idle_count", 32'(fifo_count), 0);
`ifdef COLLECTOR_TIMEOUT_EN
    chk("timeout_pulses", 32'(pulses), 1);
`else
    chk("timeout_pulses", 32'(pulses), 0);
`endif
    valid = 1'b1; data_bus = 8'h11; step();
    data_bus = 8'h22; step(); valid = 1'b0;
    step();
    chk("after_idle_count", 32'(fifo_count), 1);
`ifdef COLLECTOR_TIMEOUT_EN
    chk("after_idle_wout", 32'(word_out), 32'h2211);
`else
    chk("after_idle_wout", 32'(word_out), 32'h1177);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
